// File: rtl/multicycle_control_fsm_if.sv
// rtl/multicycle_control_fsm_if.sv - control bus between the multi-cycle FSM and memories/datapath
//
// Purpose: bundles the memory handshakes, branch result and every datapath
// control strobe of multicycle_control_fsm.
// master modport: the control FSM (takes instr/readies/br_taken, drives controls)
// slave modport : memories + datapath (drive instr/readies/br_taken, take controls)
// state_dbg encoding: 0 IDLE, 1 FETCH, 2 DECODE, 3 EXEC, 4 MEM, 5 WB, 6 TRAP

interface multicycle_control_fsm_if;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        br_taken;
    logic        imem_req;
    logic        dmem_req;
    logic        IRWrite;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        RegWEn;
    logic        MemRW;
    logic [1:0]  WBSel;
    logic        ALUSrc;
    logic [1:0]  ALUASel;
    logic [1:0]  ALUOp;
    logic        BrUn;
    logic        instr_done;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state_dbg;

    modport master (
        input  instr, imem_ready, dmem_ready, br_taken,
        output imem_req, dmem_req, IRWrite, PCWrite, PCSrc, RegWEn, MemRW,
               WBSel, ALUSrc, ALUASel, ALUOp, BrUn, instr_done, trap,
               trap_cause, state_dbg
    );

    modport slave (
        output instr, imem_ready, dmem_ready, br_taken,
        input  imem_req, dmem_req, IRWrite, PCWrite, PCSrc, RegWEn, MemRW,
               WBSel, ALUSrc, ALUASel, ALUOp, BrUn, instr_done, trap,
               trap_cause, state_dbg
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle RV32I control FSM with memory timeout and illegal trap
//
// Purpose: sequences each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshaking with instruction and data memory and driving the shared datapath.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - multicycle_control_fsm_if.master: instr/imem_ready/dmem_ready/br_taken
//           in; memory requests, datapath strobes, trap status and state_dbg out
// Parameters:
//   MEM_TIMEOUT     - max wait cycles for a memory ready before trapping (0 = unbounded)
//   TRAP_ON_ILLEGAL - 1: unknown opcode traps; 0: unknown opcode retires as a NOP

module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT     = 16,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_fsm_if.master bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    // A zero timeout still needs a one-bit counter so the declarations stay legal.
    localparam bit            TMO_EN   = (MEM_TIMEOUT > 0);
    localparam int            CW       = TMO_EN ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = TMO_EN ? CW'(MEM_TIMEOUT - 1) : '0;

    logic [2:0]    state_q, state_d;
    logic [6:0]    op_q, op_d;
    logic [2:0]    f3_q, f3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          trap_q, trap_d;
    logic [1:0]    cause_q, cause_d;

    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
    logic is_legal;
    logic tmo_hit;

    assign is_r     = (op_q == OP_R);
    assign is_i     = (op_q == OP_I);
    assign is_ld    = (op_q == OP_LOAD);
    assign is_st    = (op_q == OP_STORE);
    assign is_br    = (op_q == OP_B);
    assign is_jal   = (op_q == OP_JAL);
    assign is_jalr  = (op_q == OP_JALR);
    assign is_lui   = (op_q == OP_LUI);
    assign is_auipc = (op_q == OP_AUIPC);
    assign is_legal = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr
                    | is_lui | is_auipc;

    // The counter holds completed wait cycles; this is the last one allowed.
    // A ready in this same cycle takes priority over the trap.
    assign tmo_hit = TMO_EN && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        f3_d    = f3_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = S_DECODE;
                    op_d    = bus.instr[6:0];
                    f3_d    = bus.instr[14:12];
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_IMEM;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXEC;
                end else if (TRAP_ON_ILLEGAL) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                if (is_br)              state_d = S_FETCH;
                else if (is_ld | is_st) state_d = S_MEM;
                else                    state_d = S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = is_st ? S_FETCH : S_WB;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = CAUSE_DMEM;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase

        // Staying in FETCH/MEM implies the ready did not arrive this cycle.
        if (state_d != state_q)
            cnt_d = '0;
        else if (TMO_EN && ((state_q == S_FETCH) || (state_q == S_MEM)))
            cnt_d = cnt_q + CW'(1);
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            f3_q    <= '0;
            cnt_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            f3_q    <= f3_d;
            cnt_q   <= cnt_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
        end
    end

    // Moore decode; only the retire strobes follow the ready/branch inputs.
    always_comb begin
        bus.imem_req   = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.PCSrc      = 2'b00;
        bus.RegWEn     = 1'b0;
        bus.MemRW      = 1'b0;
        bus.WBSel      = 2'b00;
        bus.ALUSrc     = 1'b0;
        bus.ALUASel    = 2'b00;
        bus.ALUOp      = 2'b00;
        bus.BrUn       = 1'b0;
        bus.instr_done = 1'b0;
        bus.trap       = trap_q;
        bus.trap_cause = cause_q;
        bus.state_dbg  = state_q;
        case (state_q)
            S_FETCH: begin
                bus.imem_req = 1'b1;
                bus.IRWrite  = bus.imem_ready;
            end
            S_DECODE: begin
                if (!is_legal && !TRAP_ON_ILLEGAL) begin
                    bus.PCWrite    = 1'b1;
                    bus.instr_done = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    bus.ALUOp  = 2'b00;
                end else if (is_i) begin
                    bus.ALUOp  = 2'b10;
                    bus.ALUSrc = 1'b1;
                end else if (is_ld | is_st | is_jalr) begin
                    bus.ALUOp  = 2'b01;
                    bus.ALUSrc = 1'b1;
                end else if (is_lui) begin
                    bus.ALUASel = 2'b10;
                    bus.ALUOp   = 2'b01;
                    bus.ALUSrc  = 1'b1;
                end else if (is_auipc | is_jal) begin
                    bus.ALUASel = 2'b01;
                    bus.ALUOp   = 2'b01;
                    bus.ALUSrc  = 1'b1;
                end else if (is_br) begin
                    bus.ALUOp      = 2'b11;
                    bus.BrUn       = (f3_q[2:1] == 2'b11);
                    bus.PCWrite    = 1'b1;
                    bus.PCSrc      = bus.br_taken ? 2'b01 : 2'b00;
                    bus.instr_done = 1'b1;
                end
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.MemRW    = is_st;
                if (is_st && bus.dmem_ready) begin
                    bus.PCWrite    = 1'b1;
                    bus.instr_done = 1'b1;
                end
            end
            S_WB: begin
                bus.RegWEn     = 1'b1;
                bus.PCWrite    = 1'b1;
                bus.instr_done = 1'b1;
                bus.WBSel      = is_ld ? 2'b01 : ((is_jal | is_jalr) ? 2'b10 : 2'b00);
                bus.PCSrc      = is_jal ? 2'b01 : (is_jalr ? 2'b10 : 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - randomized self-checking bench for multicycle_control_fsm

module tb_multicycle_control_fsm;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd4;
    localparam logic [2:0] ST_WB     = 3'd5;
    localparam logic [2:0] ST_TRAP   = 3'd6;

    localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_B = 4, C_JAL = 5,
                   C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_SW   = 32'h0030A223;
    localparam logic [31:0] I_BLTU = 32'h0020E463;
    localparam logic [31:0] I_JALR = 32'h000080E7;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       dmem_req;
        logic       irw;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       regw;
        logic       memrw;
        logic [1:0] wbsel;
        logic       alusrc;
        logic [1:0] aluasel;
        logic [1:0] aluop;
        logic       brun;
        logic       done;
        logic       trap;
        logic [1:0] cause;
    } ctl_t;

    typedef struct packed {
        logic ir;
        logic dr;
        logic bt;
        ctl_t e;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        br_taken = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    multicycle_control_fsm_if ifa ();
    multicycle_control_fsm_if ifb ();

    assign ifa.instr = instr;
    assign ifa.imem_ready = imem_ready;
    assign ifa.dmem_ready = dmem_ready;
    assign ifa.br_taken = br_taken;
    assign ifb.instr = instr;
    assign ifb.imem_ready = imem_ready;
    assign ifb.dmem_ready = dmem_ready;
    assign ifb.br_taken = br_taken;

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .TRAP_ON_ILLEGAL(1'b1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    multicycle_control_fsm #(.MEM_TIMEOUT(4), .TRAP_ON_ILLEGAL(1'b0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic ctl_t obs_a();
        return {ifa.state_dbg, ifa.imem_req, ifa.dmem_req, ifa.IRWrite, ifa.PCWrite,
                ifa.PCSrc, ifa.RegWEn, ifa.MemRW, ifa.WBSel, ifa.ALUSrc, ifa.ALUASel,
                ifa.ALUOp, ifa.BrUn, ifa.instr_done, ifa.trap, ifa.trap_cause};
    endfunction

    function automatic ctl_t obs_b();
        return {ifb.state_dbg, ifb.imem_req, ifb.dmem_req, ifb.IRWrite, ifb.PCWrite,
                ifb.PCSrc, ifb.RegWEn, ifb.MemRW, ifb.WBSel, ifb.ALUSrc, ifb.ALUASel,
                ifb.ALUOp, ifb.BrUn, ifb.instr_done, ifb.trap, ifb.trap_cause};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t mk(input logic [2:0] st);
        ctl_t c = '0;
        c.st = st;
        return c;
    endfunction

    function automatic void push(input logic ir, input logic dr, input logic bt, input ctl_t c);
        ent_t en;
        en.ir = ir;
        en.dr = dr;
        en.bt = bt;
        en.e  = c;
        q.push_back(en);
    endfunction

    function automatic void push_trap(input logic [1:0] cause, input int n);
        ctl_t c = mk(ST_TRAP);
        c.trap  = 1'b1;
        c.cause = cause;
        for (int k = 0; k < n; k++) push(rb(), rb(), rb(), c);
    endfunction

    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LD;
            7'b0100011: return C_ST;
            7'b1100011: return C_B;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return C_AUIPC;
            default:    return C_ILL;
        endcase
    endfunction

    // Expected cycle-by-cycle profile of one instruction, phase by phase.
    // iw/dw are the number of cycles each memory withholds its ready.
    function automatic void build(input logic [31:0] ins, input int iw, input int dw,
                                  input logic bt, input bit toi, input int tmo);
        ctl_t c;
        int   cls = classify(ins[6:0]);
        int   nw;
        logic [2:0] f3 = ins[14:12];

        nw = (tmo != 0 && iw >= tmo) ? tmo : iw;
        for (int k = 0; k < nw; k++) begin
            c = mk(ST_FETCH);
            c.imem_req = 1'b1;
            push(1'b0, rb(), rb(), c);
        end
        if (tmo != 0 && iw >= tmo) begin
            push_trap(2'b10, 4);
            return;
        end
        c = mk(ST_FETCH);
        c.imem_req = 1'b1;
        c.irw = 1'b1;
        push(1'b1, rb(), rb(), c);

        c = mk(ST_DECODE);
        if (cls == C_ILL) begin
            if (toi) begin
                push(rb(), rb(), rb(), c);
                push_trap(2'b01, 4);
            end else begin
                c.pcw  = 1'b1;
                c.done = 1'b1;
                push(rb(), rb(), rb(), c);
            end
            return;
        end
        push(rb(), rb(), rb(), c);

        c = mk(ST_EXEC);
        case (cls)
            C_R:                  c.aluop = 2'b00;
            C_I:                  begin c.aluop = 2'b10; c.alusrc = 1'b1; end
            C_LD, C_ST, C_JALR:   begin c.aluop = 2'b01; c.alusrc = 1'b1; end
            C_LUI:                begin c.aluasel = 2'b10; c.aluop = 2'b01; c.alusrc = 1'b1; end
            C_AUIPC, C_JAL:       begin c.aluasel = 2'b01; c.aluop = 2'b01; c.alusrc = 1'b1; end
            default:              c.aluop = 2'b11;
        endcase
        if (cls == C_B) begin
            c.brun  = (f3 == 3'b110) || (f3 == 3'b111);
            c.pcw   = 1'b1;
            c.done  = 1'b1;
            c.pcsrc = bt ? 2'b01 : 2'b00;
            push(rb(), rb(), bt, c);
            return;
        end
        push(rb(), rb(), rb(), c);

        if (cls == C_LD || cls == C_ST) begin
            nw = (tmo != 0 && dw >= tmo) ? tmo : dw;
            for (int k = 0; k < nw; k++) begin
                c = mk(ST_MEM);
                c.dmem_req = 1'b1;
                c.memrw = (cls == C_ST);
                push(rb(), 1'b0, rb(), c);
            end
            if (tmo != 0 && dw >= tmo) begin
                push_trap(2'b11, 4);
                return;
            end
            c = mk(ST_MEM);
            c.dmem_req = 1'b1;
            c.memrw = (cls == C_ST);
            c.pcw = (cls == C_ST);
            c.done = (cls == C_ST);
            push(rb(), 1'b1, rb(), c);
            if (cls == C_ST) return;
        end

        c = mk(ST_WB);
        c.regw  = 1'b1;
        c.pcw   = 1'b1;
        c.done  = 1'b1;
        c.wbsel = (cls == C_LD) ? 2'b01 : ((cls == C_JAL || cls == C_JALR) ? 2'b10 : 2'b00);
        c.pcsrc = (cls == C_JAL) ? 2'b01 : ((cls == C_JALR) ? 2'b10 : 2'b00);
        push(rb(), rb(), rb(), c);
    endfunction

    task automatic play(input string tag, input bit chk_a, input bit chk_b, input int lim);
        ent_t en;
        int   n = 0;
        while (q.size() > 0 && n < lim) begin
            en = q.pop_front();
            @(negedge clk);
            imem_ready = en.ir;
            dmem_ready = en.dr;
            br_taken   = en.bt;
            #1;
            if (chk_a) check_eq($sformatf("%s_a_c%0d", tag, n), {9'b0, obs_a()}, {9'b0, en.e});
            if (chk_b) check_eq($sformatf("%s_b_c%0d", tag, n), {9'b0, obs_b()}, {9'b0, en.e});
            n++;
        end
        q.delete();
    endtask

    task automatic run(input string tag, input logic [31:0] ins, input int iw, input int dw,
                       input logic bt, input bit toi, input int tmo,
                       input bit chk_a, input bit chk_b, input int lim);
        instr = ins;
        build(ins, iw, dw, bt, toi, tmo);
        play(tag, chk_a, chk_b, lim);
    endtask

    // Reset takes effect without waiting for a clock edge; IDLE is checked both
    // while asserted and right after release.
    task automatic do_reset(input string tag);
        ctl_t idle = mk(ST_IDLE);
        @(negedge clk);
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        br_taken = 1'b0;
        #1;
        check_eq({tag, "_rst_a"}, {9'b0, obs_a()}, {9'b0, idle});
        check_eq({tag, "_rst_b"}, {9'b0, obs_b()}, {9'b0, idle});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq({tag, "_rel_a"}, {9'b0, obs_a()}, {9'b0, idle});
        check_eq({tag, "_rel_b"}, {9'b0, obs_b()}, {9'b0, idle});
    endtask

    function automatic logic [31:0] gen_legal();
        logic [6:0] op;
        logic [2:0] f3 = 3'($urandom_range(0, 7));
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 8))
            0: op = 7'b0110011;
            1: op = 7'b0010011;
            2: op = 7'b0000011;
            3: op = 7'b0100011;
            4: begin
                op = 7'b1100011;
                case ($urandom_range(0, 5))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b100;
                    3: f3 = 3'b101;
                    4: f3 = 3'b110;
                    default: f3 = 3'b111;
                endcase
            end
            5: op = 7'b1101111;
            6: op = 7'b1100111;
            7: op = 7'b0110111;
            default: op = 7'b0010111;
        endcase
        return {r[31:15], f3, r[11:7], op};
    endfunction

    initial begin
        logic [31:0] ins;
        repeat (2) @(negedge clk);
        do_reset("init");

        run("add",   I_ADD,  0, 0, 1'b0, 1'b1, 16, 1'b1, 1'b1, 100);
        run("lw_d3", I_LW,   0, 3, 1'b0, 1'b1, 16, 1'b1, 1'b1, 100);
        run("bltu_t", I_BLTU, 0, 0, 1'b1, 1'b1, 16, 1'b1, 1'b1, 100);
        run("bltu_n", I_BLTU, 0, 0, 1'b0, 1'b1, 16, 1'b1, 1'b1, 100);
        run("jalr",  I_JALR, 0, 0, 1'b0, 1'b1, 16, 1'b1, 1'b1, 100);
        run("sw",    I_SW,   1, 0, 1'b0, 1'b1, 16, 1'b1, 1'b1, 100);

        for (int i = 0; i < 40; i++) begin
            ins = gen_legal();
            run($sformatf("rnd%0d", i), ins, $urandom_range(0, 3), $urandom_range(0, 3),
                rb(), 1'b1, 16, 1'b1, 1'b1, 100);
        end

        // Illegal opcode: trapping and retiring variants.
        do_reset("ill_a");
        run("ill_a", I_ILL, 0, 0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 100);
        do_reset("ill_b");
        run("ill_b", I_ILL, 0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 100);
        run("ill_b_next", I_ADD, 0, 0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 100);

        // Timeout boundaries on the short-timeout instance.
        run("b_iw3", I_ADD, 3, 0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 100);
        run("b_dw3", I_SW,  0, 3, 1'b0, 1'b0, 4, 1'b0, 1'b1, 100);
        run("b_dw4", I_LW,  0, 4, 1'b0, 1'b0, 4, 1'b0, 1'b1, 100);
        do_reset("b_tmo");
        run("b_iw4", I_ADD, 4, 0, 1'b0, 1'b0, 4, 1'b0, 1'b1, 100);

        // Instruction-fetch timeout on the default instance.
        do_reset("a_tmo");
        run("a_iw15", I_ADD, 15, 0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 100);
        run("a_iw16", I_ADD, 16, 0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 100);
        do_reset("a_trap_exit");

        // Reset while a store is waiting in MEM must drop dmem_req at once.
        run("sw_cut", I_SW, 0, 3, 1'b0, 1'b1, 16, 1'b1, 1'b1, 4);
        do_reset("mid");
        run("after", I_ADD, 0, 0, 1'b0, 1'b1, 16, 1'b1, 1'b1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
